id_instr_buffer: RTL and testbench
==================================

Name: id_instr_buffer

Overview:
- Small in-order instruction buffer at the IF→ID boundary; decouples fetch from decode with a valid/ready handshake on both sides.
- The head entry is presented to the decode stage with its 64-bit immediate already expanded. The buffer instantiates the existing immediate generator, driven by the head instruction.
- Supports pipeline flush on branch mispredict or exception redirect.

Parameters:
- DEPTH, 2, number of entries; power of two, ≥2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  asynchronous active-low reset
- flush_i  in  1  discard all entries
- valid_i  in  1  fetch presents an instruction
- instr_i  in  32  fetched instruction word (instruction_t)
- pc_i  in  64  PC of instr_i
- ready_o  out  1  buffer can accept this cycle
- valid_o  out  1  head entry valid
- instr_o  out  32  head instruction
- pc_o  out  64  head PC
- imm_o  out  64  immediate of head instruction (bus64_t)
- ready_i  in  1  decode consumes head this cycle
- count_o  out  PTR_W+1  current occupancy

Behaviour:
- Reset (rstn_i low, asynchronous): all of the following are cleared.
  - count, rd_ptr and wr_ptr ← 0.
  - Storage contents don't-care.
  - valid_o=0, ready_o=1, count_o=0.
  - instr_o, pc_o and imm_o read 0.
- Push: occurs when valid_i && ready_o.
  - At the clock edge, {instr_i, pc_i} is written at wr_ptr.
  - wr_ptr increments modulo DEPTH.
- Pop: occurs when valid_o && ready_i.
  - rd_ptr increments modulo DEPTH.
- Status signals:
  - ready_o = (count != DEPTH). Purely combinational from state; no dependence on ready_i.
  - valid_o = (count != 0).
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- Latency: 1 cycle, with no empty bypass. An instruction pushed at edge N appears on valid_o/instr_o after edge N.
- Throughput: 1 instruction/cycle sustained when count is between 1 and DEPTH−1.
- Full buffer: a pop frees a slot only from the next cycle, so ready_o stays 0 in the popping cycle.
- Empty buffer: instr_o, pc_o and imm_o are forced to 0, so no stale data leaves the buffer.
- Output data:
  - instr_o and pc_o are driven combinationally from storage at rd_ptr.
  - imm_o = immediate(instr_o). The generator is purely combinational, so the immediate is valid in the same cycle as instr_o.
- Immediate generator semantics:
  - U-type (LUI/AUIPC): imm[31:12]=instr[31:12], low 12 bits 0, sign-extended to 64.
  - JAL: J-immediate, sign-extended.
  - JALR/LOAD/ALU_I/ALU_I_W: I-immediate, sign-extended.
  - BRANCH: B-immediate; STORE: S-immediate; both sign-extended.
  - SYSTEM, CSR/ECALL func3: I-immediate.
  - Other opcodes: 0.
- Flush (flush_i=1):
  - At the edge, count, rd_ptr and wr_ptr ← 0.
  - Flush dominates any push and pop in the same cycle; the incoming instruction is dropped.
  - ready_o and valid_o are not masked by flush in that cycle. Upstream and downstream must ignore handshakes during flush.
- Pointer wrap: wr_ptr/rd_ptr wrap from DEPTH−1 to 0 with no bubble.
- Error handling: count never exceeds DEPTH and never underflows. Protocol violations are impossible by construction because push is gated by ready_o and pop by valid_o.
- Reset mid-operation: asynchronous clear as above; the buffer is usable on the first edge after rstn_i deasserts.

Test Plan:
- Reset then idle: rstn_i=0 → valid_o=0, ready_o=1, count_o=0, imm_o=0.
- Single LUI: push instr_i=0x123450B7, pc_i=0x80000000 → next cycle valid_o=1, imm_o=0x0000000012345000, pc_o=0x80000000. With ready_i=1, count_o returns to 0 on the following cycle.
- ADDI sign extension: push 0xFFF00093 (ADDI x1,x0,-1), then 0xFE000EE3 (BEQ offset −4) → imm_o=0xFFFFFFFFFFFFFFFF, then 0xFFFFFFFFFFFFFFFC, in order.
- Fill and backpressure: ready_i=0, push DEPTH=2 instructions → ready_o=0 and count_o=2; a third valid_i is not accepted. Set ready_i=1 for one cycle → ready_o=1 the next cycle, and the order is preserved.
- Streaming wrap-around: 10 back-to-back pushes with ready_i=1 and PCs 0x1000, 0x1004, … → every instruction pops in order at 1 per cycle with no drops or duplicates across the pointer wrap.
- Flush with simultaneous push: count_o=2, flush_i=1 and valid_i=1 in the same cycle → next cycle count_o=0, valid_o=0, and the pushed instruction never appears. A mid-operation rstn_i pulse gives the same observable result without waiting for a clock edge.

Source files
------------

// File: rtl/id_instr_buffer.sv
// In-order IF->ID instruction buffer with valid/ready on both sides.
// The head entry is presented with its 64-bit immediate already expanded.
module id_instr_buffer #(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [31:0]       instr_i,
  input  logic [63:0]       pc_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [31:0]       instr_o,
  output logic [63:0]       pc_o,
  output logic [63:0]       imm_o,
  input  logic              ready_i,
  output logic [PTR_W:0]    count_o
);

  localparam logic [PTR_W:0] Full = (PTR_W + 1)'(DEPTH);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpAluI   = 7'b0010011;
  localparam logic [6:0] OpAluIW  = 7'b0011011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      instr_mem [DEPTH];
  logic [63:0]      pc_mem    [DEPTH];
  logic             push, pop;

  assign ready_o = (count_q != Full);
  assign valid_o = (count_q != '0);
  assign count_o = count_q;
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;

  // Flush wins over any handshake in the same cycle; the incoming word is dropped.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage needs no reset: it is only observed while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      instr_mem[wr_ptr_q] <= instr_i;
      pc_mem[wr_ptr_q]    <= pc_i;
    end
  end

  always_comb begin
    instr_o = '0;
    pc_o    = '0;
    if (valid_o) begin
      instr_o = instr_mem[rd_ptr_q];
      pc_o    = pc_mem[rd_ptr_q];
    end
  end

  // Immediate generator on the head instruction.
  always_comb begin
    imm_o = '0;
    case (instr_o[6:0])
      OpLui, OpAuipc:
        imm_o = {{32{instr_o[31]}}, instr_o[31:12], 12'b0};
      OpJal:
        imm_o = {{43{instr_o[31]}}, instr_o[31], instr_o[19:12], instr_o[20],
                 instr_o[30:21], 1'b0};
      OpJalr, OpLoad, OpAluI, OpAluIW, OpSystem:
        imm_o = {{52{instr_o[31]}}, instr_o[31:20]};
      OpBranch:
        imm_o = {{51{instr_o[31]}}, instr_o[31], instr_o[7], instr_o[30:25],
                 instr_o[11:8], 1'b0};
      OpStore:
        imm_o = {{52{instr_o[31]}}, instr_o[31:25], instr_o[11:7]};
      default:
        imm_o = '0;
    endcase
  end

endmodule

// File: tb/tb_id_instr_buffer.sv
// Directed bench for id_instr_buffer: reset, immediates, backpressure,
// streaming wrap-around, flush and asynchronous reset.
module tb_id_instr_buffer;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic             clk_i = 1'b0;
  logic             rstn_i = 1'b0;
  logic             flush_i = 1'b0;
  logic             valid_i = 1'b0;
  logic [31:0]      instr_i = '0;
  logic [63:0]      pc_i = '0;
  logic             ready_o;
  logic             valid_o;
  logic [31:0]      instr_o;
  logic [63:0]      pc_o;
  logic [63:0]      imm_o;
  logic             ready_i = 1'b0;
  logic [PTR_W:0]   count_o;

  int n_vec = 0;
  int n_err = 0;

  id_instr_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .instr_i (instr_i),
    .pc_i    (pc_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .instr_o (instr_o),
    .pc_o    (pc_o),
    .imm_o   (imm_o),
    .ready_i (ready_i),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc);
    valid_i = v;
    instr_i = ins;
    pc_i    = pc;
  endtask

  initial begin
    // Reset and idle.
    #1;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_imm",   imm_o, 64'd0);
    check("rst_instr", 64'(instr_o), 64'd0);
    check("rst_pc",    pc_o, 64'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    step();

    // Single LUI.
    drive(1'b1, 32'h123450B7, 64'h80000000);
    step();
    drive(1'b0, '0, '0);
    check("lui_valid", 64'(valid_o), 64'd1);
    check("lui_instr", 64'(instr_o), 64'h123450B7);
    check("lui_pc",    pc_o, 64'h80000000);
    check("lui_imm",   imm_o, 64'h0000000012345000);
    check("lui_count", 64'(count_o), 64'd1);
    ready_i = 1'b1;
    step();
    check("lui_pop_count", 64'(count_o), 64'd0);
    check("lui_pop_valid", 64'(valid_o), 64'd0);
    check("empty_imm",     imm_o, 64'd0);
    check("empty_pc",      pc_o, 64'd0);

    // ADDI -1 then BEQ -4, drained in order.
    ready_i = 1'b0;
    drive(1'b1, 32'hFFF00093, 64'h100);
    step();
    drive(1'b1, 32'hFE000EE3, 64'h104);
    step();
    drive(1'b0, '0, '0);
    check("sx_full_count", 64'(count_o), 64'd2);
    check("sx_full_ready", 64'(ready_o), 64'd0);
    check("sx_addi_imm",   imm_o, 64'hFFFFFFFFFFFFFFFF);
    ready_i = 1'b1;
    step();
    check("sx_beq_imm",    imm_o, 64'hFFFFFFFFFFFFFFFC);
    check("sx_beq_pc",     pc_o, 64'h104);
    step();
    check("sx_drain",      64'(count_o), 64'd0);

    // Fill, backpressure, third push refused while full.
    ready_i = 1'b0;
    drive(1'b1, 32'h00100093, 64'h200);
    step();
    drive(1'b1, 32'h00200093, 64'h204);
    step();
    check("bp_count", 64'(count_o), 64'd2);
    check("bp_ready", 64'(ready_o), 64'd0);
    drive(1'b1, 32'h00300093, 64'h208);
    ready_i = 1'b1;
    step();
    drive(1'b0, '0, '0);
    check("bp_pop_ready", 64'(ready_o), 64'd1);
    check("bp_pop_count", 64'(count_o), 64'd1);
    check("bp_order_pc",  pc_o, 64'h204);
    check("bp_order_imm", imm_o, 64'd2);
    step();
    check("bp_no_third", 64'(valid_o), 64'd0);

    // Streaming across pointer wrap: one in, one out every cycle.
    ready_i = 1'b1;
    drive(1'b1, 32'h00000013, 64'h1000);
    step();
    for (int i = 1; i < 10; i++) begin
      check("st_valid", 64'(valid_o), 64'd1);
      check("st_count", 64'(count_o), 64'd1);
      check("st_pc",    pc_o, 64'h1000 + 64'(4 * (i - 1)));
      check("st_imm",   imm_o, 64'(i - 1));
      drive(1'b1, 32'h00000013 | (32'(i) << 20), 64'h1000 + 64'(4 * i));
      step();
    end
    drive(1'b0, '0, '0);
    check("st_last_pc",  pc_o, 64'h1024);
    check("st_last_imm", imm_o, 64'd9);
    step();
    check("st_drain", 64'(count_o), 64'd0);

    // Flush while full with a simultaneous push.
    ready_i = 1'b0;
    drive(1'b1, 32'h00100093, 64'h300);
    step();
    drive(1'b1, 32'h00200093, 64'h304);
    step();
    check("fl_full", 64'(count_o), 64'd2);
    drive(1'b1, 32'h00700093, 64'h308);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    drive(1'b0, '0, '0);
    check("fl_count", 64'(count_o), 64'd0);
    check("fl_valid", 64'(valid_o), 64'd0);
    check("fl_imm",   imm_o, 64'd0);

    // Flush with one entry, an accepted push and a pop: everything discarded.
    drive(1'b1, 32'h00400093, 64'h400);
    step();
    drive(1'b1, 32'h00500093, 64'h404);
    ready_i = 1'b1;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    drive(1'b0, '0, '0);
    check("fl1_count", 64'(count_o), 64'd0);
    ready_i = 1'b0;
    drive(1'b1, 32'h00600093, 64'h408);
    step();
    drive(1'b0, '0, '0);
    check("fl1_after_pc",  pc_o, 64'h408);
    check("fl1_after_imm", imm_o, 64'd6);

    // Asynchronous reset mid-operation, observed before any clock edge.
    drive(1'b1, 32'h00800093, 64'h40C);
    step();
    drive(1'b0, '0, '0);
    check("ar_pre_count", 64'(count_o), 64'd2);
    rstn_i = 1'b0;
    #1;
    check("ar_count", 64'(count_o), 64'd0);
    check("ar_valid", 64'(valid_o), 64'd0);
    check("ar_ready", 64'(ready_o), 64'd1);
    check("ar_instr", 64'(instr_o), 64'd0);
    #1;
    rstn_i = 1'b1;
    drive(1'b1, 32'h123450B7, 64'h500);
    step();
    drive(1'b0, '0, '0);
    check("ar_use_count", 64'(count_o), 64'd1);
    check("ar_use_pc",    pc_o, 64'h500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
